// File: rtl/unified_buffer_pkg.sv
// Shared definitions for the unified buffer and its read-side clients.
package unified_buffer_pkg;

    // Default geometry of the unified buffer, shared with the buffer itself.
    localparam int UB_NUM_BANKS  = 16;
    localparam int UB_BANK_DEPTH = 4096;
    localparam int UB_DATA_WIDTH = 8;

    // Read sequencer control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } ub_state_e;

endpackage

// File: rtl/ub_skew_lane.sv
// One bank's slice of the read sequencer: decides whether this bank reads in
// the upcoming issue cycle, where it reads, and delays that valid by the
// buffer's one-cycle read latency to mark data arriving at the array edge.
module ub_skew_lane
    import unified_buffer_pkg::*;
#(
    parameter int BANK       = 0,
    parameter int BANK_DEPTH = UB_BANK_DEPTH,
    parameter int ROW_BITS   = $clog2(UB_BANK_DEPTH),
    parameter int CNT_BITS   = ROW_BITS + 1 + $clog2(UB_NUM_BANKS)
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                srst_i,
    input  logic                en_i,
    input  logic                issue_i,
    input  logic [CNT_BITS-1:0] t_i,
    input  logic [ROW_BITS-1:0] base_i,
    input  logic [ROW_BITS:0]   count_i,
    output logic                readValid_o,
    output logic [ROW_BITS-1:0] readAddress_o,
    output logic                arrayValid_o
);

    localparam logic [CNT_BITS-1:0] BANK_W  = CNT_BITS'(BANK);
    localparam logic [CNT_BITS:0]   DEPTH_W = (CNT_BITS + 1)'(BANK_DEPTH);

    logic [CNT_BITS-1:0] offset;
    logic [CNT_BITS:0]   rowSum;
    logic                readValid_d;
    logic [ROW_BITS-1:0] readAddress_d;
    logic                readValid_q;
    logic [ROW_BITS-1:0] readAddress_q;
    logic                arrayValid_q;

    // Row this bank reads is t-BANK past the base; the sum never reaches twice
    // the depth, so a single conditional subtract performs the wrap.
    always_comb begin
        offset        = t_i - BANK_W;
        rowSum        = {1'b0, offset} + (CNT_BITS + 1)'(base_i);
        readValid_d   = issue_i && (t_i >= BANK_W) && (offset < CNT_BITS'(count_i));
        readAddress_d = '0;
        if (readValid_d) begin
            readAddress_d = ROW_BITS'((rowSum >= DEPTH_W) ? (rowSum - DEPTH_W) : rowSum);
        end
    end

    // Registered read request plus the one-cycle-later array-side valid.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            readValid_q   <= 1'b0;
            readAddress_q <= '0;
            arrayValid_q  <= 1'b0;
        end else if (srst_i) begin
            readValid_q   <= 1'b0;
            readAddress_q <= '0;
            arrayValid_q  <= 1'b0;
        end else if (en_i) begin
            readValid_q   <= readValid_d;
            readAddress_q <= readAddress_d;
            arrayValid_q  <= readValid_q;
        end
    end

    assign readValid_o   = readValid_q;
    assign readAddress_o = readAddress_q;
    assign arrayValid_o  = arrayValid_q;

endmodule

// File: rtl/ub_read_sequencer.sv
// Read-side client of the unified buffer: streams a block of rows out of every
// bank with a one-cycle-per-bank diagonal skew so data reaches the systolic
// array edge already staggered, and masks the buffer output when not valid.
module ub_read_sequencer
    import unified_buffer_pkg::*;
#(
    parameter  int NUM_BANKS  = UB_NUM_BANKS,
    parameter  int BANK_DEPTH = UB_BANK_DEPTH,
    parameter  int DATA_WIDTH = UB_DATA_WIDTH,
    localparam int ROW_BITS   = $clog2(BANK_DEPTH)
) (
    input  logic                         CLK,
    input  logic                         ASYNC_RST,
    input  logic                         SYNC_RST,
    input  logic                         EN,
    input  logic                         CmdValid,
    output logic                         CmdReady,
    input  logic [ROW_BITS-1:0]          CmdBaseAddress,
    input  logic [ROW_BITS:0]            CmdRowCount,
    output logic [NUM_BANKS-1:0]         ReadValid,
    output logic [ROW_BITS-1:0]          ReadAddress [NUM_BANKS],
    input  logic signed [DATA_WIDTH-1:0] ReadData [NUM_BANKS],
    output logic [NUM_BANKS-1:0]         ArrayValid,
    output logic signed [DATA_WIDTH-1:0] ArrayData [NUM_BANKS],
    output logic                         Busy,
    output logic                         Done
);

    localparam int CNT_BITS = ROW_BITS + 1 + $clog2(NUM_BANKS);

    ub_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] t_q, t_d;
    logic [ROW_BITS-1:0] base_q, base_d;
    logic [ROW_BITS:0]   count_q, count_d;
    logic [CNT_BITS-1:0] lastIssue;
    logic                issueNext;

    // The last bank finishes its last row in issue cycle count+NUM_BANKS-2.
    assign lastIssue = CNT_BITS'(count_q) + CNT_BITS'(NUM_BANKS - 2);

    // Next-state logic; with EN low every register simply holds.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        base_d  = base_q;
        count_d = count_q;
        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (CmdValid) begin
                        base_d  = CmdBaseAddress;
                        count_d = CmdRowCount;
                        t_d     = '0;
                        state_d = (CmdRowCount == '0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (t_q == lastIssue) begin
                        state_d = DRAIN;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state register; sync reset takes priority over EN.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q <= IDLE;
            t_q     <= '0;
            base_q  <= '0;
            count_q <= '0;
        end else if (SYNC_RST) begin
            state_q <= IDLE;
            t_q     <= '0;
            base_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            base_q  <= base_d;
            count_q <= count_d;
        end
    end

    // Lanes register requests for the coming cycle, so they see next-state values.
    assign issueNext = (state_d == ISSUE);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gLane
        ub_skew_lane #(
            .BANK       (b),
            .BANK_DEPTH (BANK_DEPTH),
            .ROW_BITS   (ROW_BITS),
            .CNT_BITS   (CNT_BITS)
        ) uLane (
            .clk_i         (CLK),
            .arst_ni       (ASYNC_RST),
            .srst_i        (SYNC_RST),
            .en_i          (EN),
            .issue_i       (issueNext),
            .t_i           (t_d),
            .base_i        (base_d),
            .count_i       (count_d),
            .readValid_o   (ReadValid[b]),
            .readAddress_o (ReadAddress[b]),
            .arrayValid_o  (ArrayValid[b])
        );

        assign ArrayData[b] = ArrayValid[b] ? ReadData[b] : '0;
    end

    assign CmdReady = (state_q == IDLE);
    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DRAIN);

endmodule
